// File: rtl/ltsm_sb_msg_handler.sv
// Sideband message handler: serialises LTSM messages as {msg, info, even parity}
// frames MSB first, and deserialises/checks frames arriving from the link partner.
module ltsm_sb_msg_handler #(
    parameter int SB_MSG_WIDTH = 4,
    parameter int INFO_WIDTH   = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_tx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
    input  logic [INFO_WIDTH-1:0]   i_tx_msg_info,
    output logic                    o_SB_Busy,
    output logic                    o_tx_drop,
    output logic                    o_sb_data,
    output logic                    o_sb_frame,
    input  logic                    i_sb_data,
    input  logic                    i_sb_frame,
    output logic [SB_MSG_WIDTH-1:0] o_decoded_SB_msg,
    output logic [INFO_WIDTH-1:0]   o_rx_msg_info,
    output logic                    o_rx_msg_valid,
    output logic                    o_rx_err
);
    localparam int FW = SB_MSG_WIDTH + INFO_WIDTH + 1;
    localparam int CW = $clog2(FW);
    localparam logic [CW-1:0] LAST_BIT = CW'(FW - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_GAP} tx_state_e;
    typedef enum logic       {RX_IDLE, RX_RECV}          rx_state_e;

    tx_state_e               tx_state_q, tx_state_d;
    logic [FW-1:0]           tx_shift_q, tx_shift_d;
    logic [CW-1:0]           tx_cnt_q,   tx_cnt_d;
    logic                    busy_q,     busy_d;
    logic                    drop_q,     drop_d;

    rx_state_e               rx_state_q, rx_state_d;
    logic [FW-1:0]           rx_shift_q, rx_shift_d;
    logic [CW-1:0]           rx_cnt_q,   rx_cnt_d;
    logic [SB_MSG_WIDTH-1:0] msg_q,      msg_d;
    logic [INFO_WIDTH-1:0]   info_q,     info_d;
    logic                    valid_q,    valid_d;
    logic                    err_q,      err_d;

    logic                    tx_req;
    logic [FW-1:0]           rx_word;

    assign tx_req  = i_tx_msg_valid && (i_encoded_SB_msg != '0);
    assign rx_word = {rx_shift_q[FW-2:0], i_sb_data};

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        busy_d     = busy_q;
        drop_d     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_req) begin
                    tx_state_d = TX_SHIFT;
                    tx_shift_d = {i_encoded_SB_msg, i_tx_msg_info, ^{i_encoded_SB_msg, i_tx_msg_info}};
                    tx_cnt_d   = '0;
                    busy_d     = 1'b1;
                end
            end
            TX_SHIFT: begin
                drop_d     = tx_req;
                tx_shift_d = {tx_shift_q[FW-2:0], 1'b0};
                if (tx_cnt_q == LAST_BIT) begin
                    tx_state_d = TX_GAP;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d   = tx_cnt_q + CW'(1);
                end
            end
            TX_GAP: begin
                drop_d     = tx_req;
                tx_state_d = TX_IDLE;
                busy_d     = 1'b0;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // A completed frame is judged in the same edge that samples its last bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        msg_d      = msg_q;
        info_d     = info_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (i_sb_frame) begin
                    rx_state_d = RX_RECV;
                    rx_shift_d = rx_word;
                    rx_cnt_d   = CW'(1);
                end
            end
            RX_RECV: begin
                if (!i_sb_frame) begin
                    rx_state_d = RX_IDLE;
                    rx_shift_d = '0;
                    rx_cnt_d   = '0;
                    err_d      = 1'b1;
                end else if (rx_cnt_q == LAST_BIT) begin
                    rx_state_d = RX_IDLE;
                    rx_shift_d = '0;
                    rx_cnt_d   = '0;
                    if (^rx_word) begin
                        err_d = 1'b1;
                    end else if (rx_word[FW-1 -: SB_MSG_WIDTH] != '0) begin
                        msg_d   = rx_word[FW-1 -: SB_MSG_WIDTH];
                        info_d  = rx_word[INFO_WIDTH:1];
                        valid_d = 1'b1;
                    end
                end else begin
                    rx_shift_d = rx_word;
                    rx_cnt_d   = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        // NOTE: the reset also clears the shift registers and held message, so nothing powers up stale.
        if (!i_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            msg_q      <= '0;
            info_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            msg_q      <= msg_d;
            info_q     <= info_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign o_sb_frame       = (tx_state_q == TX_SHIFT);
    assign o_sb_data        = o_sb_frame && tx_shift_q[FW-1];
    assign o_SB_Busy        = busy_q;
    assign o_tx_drop        = drop_q;
    assign o_decoded_SB_msg = msg_q;
    assign o_rx_msg_info    = info_q;
    assign o_rx_msg_valid   = valid_q;
    assign o_rx_err         = err_q;

endmodule

// File: tb/tb_ltsm_sb_msg_handler.sv
// Loopback/injection bench for ltsm_sb_msg_handler; expectations come from a
// per-cycle schedule built from the framing rules, not from the RTL's state machines.
module tb_ltsm_sb_msg_handler;
    localparam int FW = 8;
    localparam int N  = 4096;

    logic       clk = 1'b0;
    logic       rst_n, tx_valid;
    logic [3:0] tx_msg;
    logic [2:0] tx_info;
    logic       inj_mode, inj_frame, inj_data;
    logic       sb_data_o, sb_frame_o, line_data, line_frame;
    logic       busy, drop, rx_valid, rx_err;
    logic [3:0] rx_msg;
    logic [2:0] rx_info;

    always #5 clk = ~clk;

    assign line_data  = inj_mode ? inj_data  : sb_data_o;
    assign line_frame = inj_mode ? inj_frame : sb_frame_o;

    ltsm_sb_msg_handler #(.SB_MSG_WIDTH(4), .INFO_WIDTH(3)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_tx_msg_valid   (tx_valid),
        .i_encoded_SB_msg (tx_msg),
        .i_tx_msg_info    (tx_info),
        .o_SB_Busy        (busy),
        .o_tx_drop        (drop),
        .o_sb_data        (sb_data_o),
        .o_sb_frame       (sb_frame_o),
        .i_sb_data        (line_data),
        .i_sb_frame       (line_frame),
        .o_decoded_SB_msg (rx_msg),
        .o_rx_msg_info    (rx_info),
        .o_rx_msg_valid   (rx_valid),
        .o_rx_err         (rx_err)
    );

    // Expected output per interval following clock edge number cyc.
    int         cyc = 0, free_at = 0, n_tests = 0, n_fail = 0;
    bit         e_frame[N], e_data[N], e_busy[N], e_drop[N], e_valid[N], e_err[N];
    logic [3:0] p_msg[N];
    logic [2:0] p_info[N];
    logic [3:0] h_msg = '0;
    logic [2:0] h_info = '0;

    function automatic logic [7:0] make_frame(input logic [3:0] m, input logic [2:0] i);
        return {m, i, ^{m, i}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic schedule_tx(input int c, input logic [3:0] m, input logic [2:0] i);
        logic [7:0] w;
        w = make_frame(m, i);
        for (int k = 0; k < FW; k++) begin
            e_frame[c+k] = 1'b1;
            e_data[c+k]  = w[FW-1-k];
        end
        for (int k = 0; k <= FW; k++) e_busy[c+k] = 1'b1;
        e_valid[c+FW] = 1'b1;
        p_msg[c+FW]   = m;
        p_info[c+FW]  = i;
        free_at       = c + FW + 2;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            for (int k = cyc; k < N; k++) begin
                e_frame[k] = 0; e_data[k] = 0; e_busy[k] = 0;
                e_drop[k]  = 0; e_valid[k] = 0; e_err[k] = 0;
            end
            h_msg   = '0;
            h_info  = '0;
            free_at = cyc + 1;
        end else if (tx_valid && tx_msg != 4'd0) begin
            if (cyc >= free_at) schedule_tx(cyc, tx_msg, tx_info);
            else                e_drop[cyc] = 1'b1;
        end
        if (e_valid[cyc]) begin
            h_msg  = p_msg[cyc];
            h_info = p_info[cyc];
        end
        #1;
        check("sb_frame", sb_frame_o, e_frame[cyc]);
        check("sb_data",  sb_data_o,  e_data[cyc]);
        check("busy",     busy,       e_busy[cyc]);
        check("tx_drop",  drop,       e_drop[cyc]);
        check("rx_valid", rx_valid,   e_valid[cyc]);
        check("rx_err",   rx_err,     e_err[cyc]);
        check("rx_msg",   rx_msg,     h_msg);
        check("rx_info",  rx_info,    h_info);
    endtask

    task automatic send(input logic [3:0] m, input logic [2:0] i, input int idle_after);
        tx_valid = 1'b1; tx_msg = m; tx_info = i;
        tick();
        tx_valid = 1'b0; tx_msg = '0; tx_info = '0;
        repeat (idle_after) tick();
    endtask

    task automatic inject(input logic [7:0] w, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            inj_frame = 1'b1;
            inj_data  = w[FW-1-k];
            if (k == FW - 1) begin
                if (^w) begin
                    e_err[cyc+1] = 1'b1;
                end else if (w[7:4] != 4'd0) begin
                    e_valid[cyc+1] = 1'b1;
                    p_msg[cyc+1]   = w[7:4];
                    p_info[cyc+1]  = w[3:1];
                end
            end
            tick();
        end
    endtask

    task automatic end_inject(input bit partial);
        inj_frame = 1'b0;
        inj_data  = 1'b0;
        if (partial) e_err[cyc+1] = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; tx_valid = 1'b0; tx_msg = '0; tx_info = '0;
        inj_mode = 1'b0; inj_frame = 1'b0; inj_data = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single loopback frame, then a request arriving mid-frame that must be dropped.
        send(4'd1, 3'b010, 12);
        send(4'd2, 3'd0, 2);
        send(4'd1, 3'd7, 12);

        // Valid held high: drops while busy, re-acceptance once idle.
        tx_valid = 1'b1; tx_msg = 4'd5; tx_info = 3'd3;
        repeat (25) tick();
        tx_valid = 1'b1; tx_msg = 4'd0;
        repeat (12) tick();
        tx_valid = 1'b0;

        // Randomised requests, including zero messages.
        for (int n = 0; n < 1500; n++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_msg   = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tx_info  = 3'($urandom_range(0, 7));
            tick();
        end
        tx_valid = 1'b0; tx_msg = '0;
        repeat (12) tick();

        // Direct injection on the receive line.
        inj_mode = 1'b1;
        inject(make_frame(4'd9, 3'd5), 8);            end_inject(0);
        inject(make_frame(4'd4, 3'd3) ^ 8'h01, 8);    end_inject(0);
        inject(make_frame(4'd7, 3'd1), 5);            end_inject(1);
        inject(make_frame(4'd3, 3'd6), 8);            end_inject(0);
        inject(make_frame(4'd0, 3'd3), 8);            end_inject(0);
        inject(make_frame(4'd2, 3'd1), 8);
        inject(make_frame(4'd11, 3'd7), 8);           end_inject(0);
        for (int n = 0; n < 8; n++) begin
            logic [7:0] w;
            int         nb;
            w  = 8'($urandom_range(0, 255));
            nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 8;
            inject(w, nb);
            end_inject(nb != 8);
        end
        inj_mode = 1'b0;
        tick();

        // Reset in the middle of a frame, then a fresh transfer.
        send(4'd3, 3'd1, 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send(4'd6, 3'd4, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
